// File: rtl/flappy_frame_engine.sv
// Game-logic stage for the 8x8 LED matrix: bird, scrolling pipes, collisions and score.
// Optional feature macro: BLINK_ON_OVER_EN blinks the bird frame on each game tick while in OVER.
module flappy_frame_engine #(
  parameter int TICK_CYCLES  = 2500000,
  parameter int PIPE_SPACING = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flap,
  output logic [7:0][7:0] red_array,
  output logic [7:0][7:0] green_array,
  output logic            game_over,
  output logic [7:0]      score
);

  localparam int TW = $clog2(TICK_CYCLES);
  localparam int SW = $clog2(PIPE_SPACING);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [SW-1:0] SPC_LAST  = SW'(PIPE_SPACING - 1);
  localparam logic [7:0][7:0] GREEN_HOME = 64'h0000_0000_0200_0000;

  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

  state_t          state, state_next;
  logic            flap_s, flap_s_d, flap_rise, flap_now;
  logic            flap_pend, flap_pend_next;
  logic [TW-1:0]   tick_cnt, tick_cnt_next;
  logic            tick;
  logic [SW-1:0]   spc_cnt, spc_cnt_next;
  logic [7:0]      lfsr;
  logic [2:0]      g, gap_top;
  logic [2:0]      bird, bird_new, bird_next;
  logic            floor_crash, hit, inj_pipe, col1_any, pipe_bit;
  logic [7:0][7:0] red_new, red_next, green_next;
  logic [7:0]      score_next;
  logic            game_over_next;
`ifdef BLINK_ON_OVER_EN
  logic            blink, blink_next;
`endif

  // The flap synchroniser keeps sampling during reset so a button held
  // through reset does not look like a fresh edge afterwards.
  always_ff @(posedge clock) begin
    flap_s   <= flap;
    flap_s_d <= flap_s;
  end

  assign flap_rise = flap_s & ~flap_s_d;
  assign tick      = (state != IDLE) && (tick_cnt == TICK_LAST);
  assign g         = lfsr[2:0];
  assign gap_top   = (g > 3'd5) ? g - 3'd3 : g;

  always_comb begin
    flap_now    = flap_pend | flap_rise;
    floor_crash = (bird == 3'd7) && !flap_now;
    if (flap_now)
      bird_new = (bird == 3'd0) ? 3'd0 : bird - 3'd1;
    else if (floor_crash)
      bird_new = bird;
    else
      bird_new = bird + 3'd1;
    inj_pipe = (spc_cnt == SPC_LAST);
    col1_any = 1'b0;
    pipe_bit = 1'b0;
    red_new  = '0;
    for (int r = 0; r < 8; r++) begin
      pipe_bit   = !((4'(r) >= {1'b0, gap_top}) && (4'(r) <= ({1'b0, gap_top} + 4'd2)));
      red_new[r] = {inj_pipe & pipe_bit, red_array[r][7:1]};
      col1_any   = col1_any | red_new[r][1];
    end
    hit = red_new[bird_new][1];
  end

  always_ff @(posedge clock) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Next-state and next-frame logic; a whole game step lands on one tick edge.
  always_comb begin
    state_next     = state;
    tick_cnt_next  = tick_cnt;
    spc_cnt_next   = spc_cnt;
    flap_pend_next = flap_pend;
    bird_next      = bird;
    red_next       = red_array;
    score_next     = score;
    case (state)
      IDLE: begin
        tick_cnt_next  = '0;
        spc_cnt_next   = '0;
        flap_pend_next = 1'b0;
        bird_next      = 3'd3;
        red_next       = '0;
        score_next     = 8'd0;
        if (flap_rise)
          state_next = PLAY;
      end
      PLAY: begin
        tick_cnt_next  = tick ? '0 : tick_cnt + TW'(1);
        flap_pend_next = !tick && (flap_pend || flap_rise);
        if (tick) begin
          bird_next    = bird_new;
          red_next     = red_new;
          spc_cnt_next = inj_pipe ? '0 : spc_cnt + SW'(1);
          if (floor_crash || hit)
            state_next = OVER;
          else if (col1_any && (score != 8'hFF))
            score_next = score + 8'd1;
        end
      end
      OVER: begin
        tick_cnt_next  = tick ? '0 : tick_cnt + TW'(1);
        flap_pend_next = 1'b0;
        if (flap_rise) begin
          state_next    = IDLE;
          tick_cnt_next = '0;
          bird_next     = 3'd3;
          red_next      = '0;
          score_next    = 8'd0;
        end
      end
      default: state_next = IDLE;
    endcase
    game_over_next = (state_next == OVER);
    green_next = '0;
    green_next[bird_next][1] = 1'b1;
`ifdef BLINK_ON_OVER_EN
    blink_next = ((state == OVER) && (state_next == OVER)) ? (blink ^ tick) : 1'b0;
    if (blink_next)
      green_next = '0;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tick_cnt    <= '0;
      spc_cnt     <= '0;
      flap_pend   <= 1'b0;
      lfsr        <= 8'hA5;
      bird        <= 3'd3;
      red_array   <= '0;
      green_array <= GREEN_HOME;
      game_over   <= 1'b0;
      score       <= 8'd0;
`ifdef BLINK_ON_OVER_EN
      blink       <= 1'b0;
`endif
    end else begin
      tick_cnt    <= tick_cnt_next;
      spc_cnt     <= spc_cnt_next;
      flap_pend   <= flap_pend_next;
      lfsr        <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      bird        <= bird_next;
      red_array   <= red_next;
      green_array <= green_next;
      game_over   <= game_over_next;
      score       <= score_next;
`ifdef BLINK_ON_OVER_EN
      blink       <= blink_next;
`endif
    end
  end

endmodule

// File: tb/tb_flappy_frame_engine.sv
// Self-checking bench for flappy_frame_engine with TICK_CYCLES=4 and PIPE_SPACING=4.
// Per-tick expectations go through a scoreboard queue; pipe gaps come from a reference LFSR.
`timescale 1ns/1ps
module tb_flappy_frame_engine;

  localparam int TICK    = 4;
  localparam int SPACING = 4;
  localparam logic [63:0] HOME = 64'h0000_0000_0200_0000;

  logic            clock = 1'b0;
  logic            reset;
  logic            flap;
  logic [7:0][7:0] red_array;
  logic [7:0][7:0] green_array;
  logic            game_over;
  logic [7:0]      score;

  flappy_frame_engine #(
    .TICK_CYCLES (TICK),
    .PIPE_SPACING(SPACING)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .flap       (flap),
    .red_array  (red_array),
    .green_array(green_array),
    .game_over  (game_over),
    .score      (score)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         tick;
    int         nflap;
    logic [2:0] bird;
    logic       blank;
    logic       go;
    logic [7:0] score;
    int         red_chk;
    int         red_col;
    logic       capture;
    logic [7:0] pipe;
  } vec_t;

  vec_t       sb[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  string      scen     = "init";
  logic [7:0] ref_lfsr;
  logic [7:0] pipe4    = 8'h00;
  int         gap4     = 0;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [7:0] ahead(input logic [7:0] v, input int n);
    logic [7:0] x;
    x = v;
    for (int i = 0; i < n; i++) x = lfsr_step(x);
    return x;
  endfunction

  function automatic int gap_of(input logic [7:0] v);
    int gv;
    gv = int'(v[2:0]);
    return (gv > 5) ? gv - 3 : gv;
  endfunction

  function automatic logic [7:0] pipe_of(input int gap);
    logic [7:0] m;
    for (int r = 0; r < 8; r++) m[r] = !((r >= gap) && (r <= gap + 2));
    return m;
  endfunction

  function automatic logic [63:0] frame_of(input int row);
    logic [7:0][7:0] f;
    f = '0;
    f[row][1] = 1'b1;
    return f;
  endfunction

  function automatic logic [7:0] column_of(input logic [7:0][7:0] a, input int c);
    logic [7:0] m;
    for (int r = 0; r < 8; r++) m[r] = a[r][c];
    return m;
  endfunction

  function automatic vec_t mk(input int tick, input int nflap, input int bird, input bit blank,
                              input bit go, input int sc, input int red_chk, input int red_col,
                              input bit capture);
    vec_t v;
    v.tick    = tick;
    v.nflap   = nflap;
    v.bird    = 3'(bird);
    v.blank   = blank;
    v.go      = go;
    v.score   = 8'(sc);
    v.red_chk = red_chk;
    v.red_col = red_col;
    v.capture = capture;
    v.pipe    = '0;
    return v;
  endfunction

  // Reference LFSR, stepped on every clock exactly like the game's generator.
  always @(posedge clock) ref_lfsr <= reset ? 8'hA5 : lfsr_step(ref_lfsr);

  task automatic compare(input string what, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s %s: got %h, expected %h", scen, what, act, exp);
    end
  endtask

  // Called right after a tick edge; drives flap pulses and ends just after the next tick edge.
  task automatic applyStimulus(input vec_t e);
    for (int c = 0; c < TICK; c++) begin
      flap = ((c == 0) && (e.nflap >= 1)) || ((c == 2) && (e.nflap >= 2));
      if (c == TICK - 1) begin
        if (e.capture) begin
          gap4  = gap_of(ref_lfsr);
          pipe4 = pipe_of(gap4);
        end
        e.pipe = pipe4;
        sb.push_back(e);
      end
      @(negedge clock);
    end
    flap = 1'b0;
  endtask

  task automatic checkOutput();
    vec_t  e;
    string tag;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL %s scoreboard: got empty queue, expected an entry", scen);
      return;
    end
    e   = sb.pop_front();
    tag = $sformatf("tick%0d", e.tick);
    compare({tag, " green"}, green_array, e.blank ? 64'd0 : frame_of(int'(e.bird)));
    compare({tag, " game_over"}, 64'(game_over), 64'(e.go));
    compare({tag, " score"}, 64'(score), 64'(e.score));
    if (e.red_chk == 1)
      compare({tag, " red"}, red_array, 64'd0);
    else if (e.red_chk == 2)
      compare($sformatf("%s red col%0d", tag, e.red_col), 64'(column_of(red_array, e.red_col)),
              64'(e.pipe));
  endtask

  task automatic startGame();
    flap = 1'b1;
    @(negedge clock);
    flap = 1'b0;
    @(negedge clock);
    compare("entry green", green_array, HOME);
    compare("entry game_over", 64'(game_over), 64'd0);
  endtask

  task automatic checkIdle(input string what);
    compare({what, " red"}, red_array, 64'd0);
    compare({what, " green"}, green_array, HOME);
    compare({what, " game_over"}, 64'(game_over), 64'd0);
    compare({what, " score"}, 64'(score), 64'd0);
  endtask

  // Two frozen OVER ticks, then a flap returns to IDLE two clocks after it is driven.
  task automatic overAndRestart(input int bird, input int sc, input int col);
    for (int k = 1; k <= 2; k++) begin
`ifdef BLINK_ON_OVER_EN
      applyStimulus(mk(100 + k, 0, bird, (k % 2) == 1, 1, sc, 2, col, 0));
`else
      applyStimulus(mk(100 + k, 0, bird, 0, 1, sc, 2, col, 0));
`endif
      checkOutput();
    end
    flap = 1'b1;
    @(negedge clock);
    flap = 1'b0;
    compare("restart after 1 clock game_over", 64'(game_over), 64'd1);
    @(negedge clock);
    checkIdle("restart");
    repeat (2) @(negedge clock);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin
    vec_t crash_tbl[5];
    vec_t ceil_tbl[5];
    int   bird;
    int   target;
    int   fl;

    crash_tbl[0] = mk(1, 0, 4, 0, 0, 0, 1, 0, 0);
    crash_tbl[1] = mk(2, 0, 5, 0, 0, 0, 1, 0, 0);
    crash_tbl[2] = mk(3, 0, 6, 0, 0, 0, 1, 0, 0);
    crash_tbl[3] = mk(4, 0, 7, 0, 0, 0, 2, 7, 1);
    crash_tbl[4] = mk(5, 0, 7, 0, 1, 0, 2, 6, 0);
    ceil_tbl[0]  = mk(1, 2, 2, 0, 0, 0, 1, 0, 0);
    ceil_tbl[1]  = mk(2, 1, 1, 0, 0, 0, 1, 0, 0);
    ceil_tbl[2]  = mk(3, 1, 0, 0, 0, 0, 1, 0, 0);
    ceil_tbl[3]  = mk(4, 1, 0, 0, 0, 0, 2, 7, 1);
    ceil_tbl[4]  = mk(5, 1, 0, 0, 0, 0, 2, 6, 0);

    scen  = "reset";
    reset = 1'b1;
    flap  = 1'b1;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    checkIdle("flap held");
    flap = 1'b0;
    repeat (3) @(negedge clock);

    scen = "floor";
    startGame();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(crash_tbl[i]);
      checkOutput();
    end
    overAndRestart(7, 0, 6);

    scen = "ceiling";
    startGame();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(ceil_tbl[i]);
      checkOutput();
    end

    scen  = "midreset";
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checkIdle("next edge");
    repeat (6) @(negedge clock);
    compare("idle hold green", green_array, HOME);

    scen = "steer";
    startGame();
    repeat (3) @(negedge clock);
    compare("tick1 not early green", green_array, HOME);
    @(negedge clock);
    compare("tick1 green", green_array, frame_of(4));
    applyStimulus(mk(2, 1, 3, 0, 0, 0, 1, 0, 0));
    checkOutput();
    applyStimulus(mk(3, 0, 4, 0, 0, 0, 1, 0, 0));
    checkOutput();
    applyStimulus(mk(4, 1, 3, 0, 0, 0, 2, 7, 1));
    checkOutput();
    bird   = 3;
    target = gap4 + 1;
    for (int t = 5; t <= 11; t++) begin
      fl   = (bird > target) ? 1 : 0;
      bird = (fl == 1) ? bird - 1 : bird + 1;
      applyStimulus(mk(t, fl, bird, 0, 0, (t >= 10) ? 1 : 0, (t <= 10) ? 2 : 0, 11 - t, 0));
      checkOutput();
    end
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    scen = "pipe hit";
    for (int i = 0; (i < 64) && (gap_of(ahead(ref_lfsr, 17)) == 0); i++) @(negedge clock);
    startGame();
    bird = 3;
    for (int t = 1; t <= 10; t++) begin
      bird = (bird > 0) ? bird - 1 : 0;
      applyStimulus(mk(t, 1, bird, 0, t == 10, 0, (t <= 3) ? 1 : 2, 11 - t, t == 4));
      checkOutput();
    end
    overAndRestart(0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
